regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the pipelined RV32I core; successor to the single-cycle register file.
- Adds configurable read and write port counts, hardwired-zero x0, and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard. Decode sets a busy bit when it issues a producer; writeback clears it.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_mp_sb.sv | 117 +++++++++++
 tb/tb_regfile_mp_sb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined RV32I register file slice.
// Holds default sizes, port-count limits, a constant-evaluable clog2 and
// the architectural address/data types.
// Optional feature used by this slice: REGFILE_BYPASS_EN (see regfile_mp_sb).
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int MAX_RD    = 4;
    localparam int MAX_WR    = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for regfile_mp_sb.
// Decode issue sets a bit, any enabled writeback clears it; when both hit the
// same register in one cycle the set wins because a newer producer is in flight.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous active-high reset, clears every busy bit
//   i_wr_en     writeback enables, one per write port
//   i_wr_addr   writeback addresses, port k at [k*AW +: AW]
//   i_iss_vld   issue strobe
//   i_iss_addr  destination register of the issued instruction
//   o_busy_vec  registered busy bits, bit 0 (x0) constant 0
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NUM_WR = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_WR-1:0]    i_wr_en,
    input  logic [NUM_WR*AW-1:0] i_wr_addr,
    input  logic                 i_iss_vld,
    input  logic [AW-1:0]        i_iss_addr,
    output logic [DEPTH-1:0]     o_busy_vec
);

    logic [DEPTH-1:0] r_busy;

    // Clears are applied first so the later issue assignment overrides them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] != '0)) begin
                    r_busy[i_wr_addr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (i_iss_vld && (i_iss_addr != '0)) begin
                r_busy[i_iss_addr] <= 1'b1;
            end
        end
    end

    assign o_busy_vec = r_busy & {{(DEPTH-1){1'b1}}, 1'b0};

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy scoreboard for the pipelined
// RV32I core. x0 reads as 0 and is never busy. Reads are combinational.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that
// matches an enabled same-cycle write (addr != 0) returns the write data
// (port 1 priority) and reports busy only if the same cycle issues to it.
// Ports:
//   CLK       clock, rising edge
//   reset     synchronous active-high reset (data and busy bits to 0)
//   rd_addr   read addresses, port i at [i*AW +: AW]
//   rd_data   read data, port i at [i*XLEN +: XLEN], combinational
//   rd_busy   busy flag of the addressed register per read port
//   wr_en     write enables, one per write port
//   wr_addr   write addresses, port k at [k*AW +: AW]
//   wr_data   write data, port k at [k*XLEN +: XLEN]
//   iss_vld   issue strobe, marks iss_addr busy
//   iss_addr  destination register of the issued instruction
//   busy_vec  registered scoreboard state
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   iss_vld,
    input  logic [AW-1:0]          iss_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    if ((NUM_RD < 1) || (NUM_RD > MAX_RD)) begin : g_bad_num_rd
        $error("regfile_mp_sb: NUM_RD out of range");
    end
    if ((NUM_WR < 1) || (NUM_WR > MAX_WR)) begin : g_bad_num_wr
        $error("regfile_mp_sb: NUM_WR out of range");
    end
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("regfile_mp_sb: DEPTH must be a power of 2, at least 2");
    end

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] w_busy_vec;

    // Later write ports assign last, so port 1 wins a same-address conflict.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                    r_mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .i_clk      (CLK),
        .i_reset    (reset),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_iss_vld  (iss_vld),
        .i_iss_addr (iss_addr),
        .o_busy_vec (w_busy_vec)
    );

    assign busy_vec = w_busy_vec;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_ra = rd_addr[i*AW +: AW];

        always_comb begin
            w_data = r_mem[w_ra];
            w_busy = w_busy_vec[w_ra];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan: the highest matching write port is seen last.
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0) &&
                    (wr_addr[k*AW +: AW] == w_ra)) begin
                    w_data = wr_data[k*XLEN +: XLEN];
                    w_busy = iss_vld && (iss_addr == w_ra);
                end
            end
`endif
            if (w_ra == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = w_data;
        assign rd_busy[i]              = w_busy;
    end

`ifndef SYNTHESIS
    a_no_x_ctrl: assert property (@(posedge CLK) disable iff (reset)
                                  !$isunknown({wr_en, iss_vld}))
        else $error("regfile_mp_sb: X on wr_en or iss_vld");
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   CLK;
    logic                   reset;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_vld;
    logic [AW-1:0]          iss_addr;
    logic [DEPTH-1:0]       busy_vec;

    regfile_mp_sb #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_vld  (iss_vld),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // kind: 0 = rd_data[idx], 1 = rd_busy[idx], 2 = busy_vec
    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic exp_rd(input string tag, input int p, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.kind = 0; x.idx = p; x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic exp_busy(input string tag, input int p, input logic e);
        exp_t x;
        x.tag = tag; x.kind = 1; x.idx = p; x.exp = {31'b0, e};
        sbq.push_back(x);
    endtask

    task automatic exp_vec(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.kind = 2; x.idx = 0; x.exp = e;
        sbq.push_back(x);
    endtask

    // Pops every pending expectation and compares against the settled outputs.
    task automatic check_all();
        exp_t        x;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            case (x.kind)
                0:       obs = rd_data[x.idx*XLEN +: XLEN];
                1:       obs = {31'b0, rd_busy[x.idx]};
                default: obs = busy_vec;
            endcase
            checks++;
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr_in();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_vld  = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int k, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[k]               = 1'b1;
        wr_addr[k*AW +: AW]    = a;
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        iss_vld  = 1'b1;
        iss_addr = a;
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        clr_in();

        // Reset state
        tick(); tick();
        reset = 1'b0;
        set_rd(0, 5); set_rd(1, 7); set_rd(2, 9); set_rd(3, 3);
        settle();
        for (int p = 0; p < NUM_RD; p++) begin
            exp_rd("rst_data", p, 32'h0);
            exp_busy("rst_busy", p, 1'b0);
        end
        exp_vec("rst_vec", 32'h0);
        check_all();

        // Dirty x5 (data and busy), then reset with competing write/issue
        wr(0, 5, 32'hDEADBEEF); iss(5);
        tick(); clr_in(); settle();
        exp_rd("x5_written", 0, 32'hDEADBEEF);
        exp_busy("x5_busy", 0, 1'b1);
        exp_vec("x5_vec", 32'h0000_0020);
        check_all();
        reset = 1'b1;
        wr(0, 5, 32'hFFFF_FFFF); iss(6);
        tick();
        reset = 1'b0; clr_in(); settle();
        exp_rd("rst_dirty_data", 0, 32'h0);
        exp_busy("rst_dirty_busy", 0, 1'b0);
        exp_vec("rst_dirty_vec", 32'h0);
        check_all();

        // x0: write both ports, issue, same-cycle and next-cycle reads
        set_rd(0, 0); set_rd(1, 0);
        wr(0, 0, 32'h12345678); wr(1, 0, 32'h12345678); iss(0);
        settle();
        exp_rd("x0_same_p0", 0, 32'h0);
        exp_rd("x0_same_p1", 1, 32'h0);
        exp_busy("x0_same_busy", 0, 1'b0);
        check_all();
        tick(); clr_in(); settle();
        exp_rd("x0_p0", 0, 32'h0);
        exp_rd("x0_p1", 1, 32'h0);
        exp_busy("x0_busy_p0", 0, 1'b0);
        exp_busy("x0_busy_p1", 1, 1'b0);
        exp_vec("x0_vec", 32'h0);
        check_all();

        // Issue x7, re-issue while busy, then write it back
        set_rd(0, 7);
        iss(7);
        tick(); clr_in(); settle();
        exp_vec("x7_set_vec", 32'h0000_0080);
        exp_busy("x7_set_busy", 0, 1'b1);
        check_all();
        iss(7);
        tick(); clr_in(); settle();
        exp_vec("x7_reissue_vec", 32'h0000_0080);
        check_all();
        tick(); settle();
        exp_vec("x7_hold_vec", 32'h0000_0080);
        check_all();
        wr(0, 7, 32'hA5A5A5A5);
        settle();
        exp_rd("x7_wr_same_data", 0, BYP ? 32'hA5A5A5A5 : 32'h0);
        exp_busy("x7_wr_same_busy", 0, BYP ? 1'b0 : 1'b1);
        check_all();
        tick(); clr_in(); settle();
        exp_vec("x7_clr_vec", 32'h0);
        exp_rd("x7_data", 0, 32'hA5A5A5A5);
        exp_busy("x7_clr_busy", 0, 1'b0);
        check_all();

        // Same-cycle issue and write of x9: set wins, data still lands
        set_rd(1, 9);
        iss(9); wr(0, 9, 32'h11);
        settle();
        exp_rd("x9_same_data", 1, BYP ? 32'h11 : 32'h0);
        exp_busy("x9_same_busy", 1, BYP ? 1'b1 : 1'b0);
        check_all();
        tick(); clr_in(); settle();
        exp_vec("x9_vec", 32'h0000_0200);
        exp_rd("x9_data", 1, 32'h11);
        exp_busy("x9_busy", 1, 1'b1);
        check_all();

        // Dual write to x3: port 1 wins; port 1 alone clears x9
        set_rd(2, 3);
        wr(0, 3, 32'h1); wr(1, 3, 32'h2);
        settle();
        exp_rd("x3_same", 2, BYP ? 32'h2 : 32'h0);
        check_all();
        tick(); clr_in(); settle();
        exp_rd("x3_data", 2, 32'h2);
        check_all();
        wr(1, 9, 32'h99);
        tick(); clr_in(); settle();
        exp_vec("x9_clr_p1_vec", 32'h0);
        exp_rd("x9_p1_data", 1, 32'h99);
        check_all();

        // Four concurrent reads of distinct registers
        wr(0, 10, 32'h10); wr(1, 11, 32'h20);
        tick(); clr_in();
        wr(0, 12, 32'h30); wr(1, 13, 32'h40);
        tick(); clr_in();
        set_rd(0, 10); set_rd(1, 11); set_rd(2, 12); set_rd(3, 13);
        settle();
        for (int p = 0; p < NUM_RD; p++) begin
            exp_rd("quad_data", p, 32'h10 * (p + 1));
            exp_busy("quad_busy", p, 1'b0);
        end
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
